dmem_rmw_unit: RTL and testbench

DMEM_RMW_UNIT -- requirements
Module: dmem_rmw_unit

---
 rtl/dmem_rmw_unit.sv | 172 +++++++++++++++++
 tb/tb_dmem_rmw_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_rmw_unit.sv
// Data-memory access unit: MIPS loads/stores on a word-wide memory,
// with read-modify-write for sub-word stores.
module dmem_rmw_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        op,
  input  logic [ADDR_W-1:0] a,
  input  logic [31:0]       wd,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t state, state_n;

  logic [5:0]        op_q;
  logic [ADDR_W-1:0] a_q;
  logic [31:0]       wd_q;
  logic [31:0]       word_q;
  logic [7:0]        cnt;
  logic              err_q;

  logic        accept;
  logic        bad_in;
  logic        rmw_q;
  logic [1:0]  lane;
  logic        hsel;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] wmerge;
  logic [31:0] rload;

  assign accept = req_valid && (state == IDLE);
  assign rmw_q  = (op_q == OP_SB) || (op_q == OP_SH);

  // Classify the incoming request: illegal op or misaligned address
  always_comb begin
    bad_in = 1'b1;
    case (op)
      OP_LB, OP_LBU, OP_SB: bad_in = 1'b0;
      OP_LH, OP_LHU, OP_SH: bad_in = a[0];
      OP_LW, OP_SW:         bad_in = |a[1:0];
      default:              bad_in = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad_in)
            state_n = RESP;
          else if (op == OP_SW)
            state_n = WRITE;
          else
            state_n = READ;
        end
      end
      READ: begin
        if (mem_rvalid)
          state_n = rmw_q ? WRITE : RESP;
        else if (cnt == TO_LAST)
          state_n = RESP;
      end
      WRITE:   state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, latched request, read counter and captured memory word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      wd_q   <= '0;
      word_q <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q   <= op;
        a_q    <= a;
        wd_q   <= wd;
        word_q <= '0;
        cnt    <= '0;
        err_q  <= bad_in;
      end
      if (state == READ) begin
        cnt <= cnt + 8'd1;
        if (mem_rvalid)
          word_q <= mem_rdata;
        else if (cnt == TO_LAST)
          err_q <= 1'b1;
      end
    end
  end

  // Byte lane 3-x equals ~x on two bits; halfword order flips likewise
  assign lane  = BIG_ENDIAN ? ~a_q[1:0] : a_q[1:0];
  assign hsel  = BIG_ENDIAN ? ~a_q[1] : a_q[1];
  assign sel_b = word_q[{lane, 3'b000} +: 8];
  assign sel_h = word_q[{hsel, 4'b0000} +: 16];

  // Store data: merge sub-word store into the captured word
  always_comb begin
    wmerge = word_q;
    case (op_q)
      OP_SB:   wmerge[{lane, 3'b000} +: 8] = wd_q[7:0];
      OP_SH:   wmerge[{hsel, 4'b0000} +: 16] = wd_q[15:0];
      OP_SW:   wmerge = wd_q;
      default: wmerge = word_q;
    endcase
  end

  // Load result extraction and extension
  always_comb begin
    rload = '0;
    case (op_q)
      OP_LB:   rload = {{24{sel_b[7]}}, sel_b};
      OP_LBU:  rload = {24'h0, sel_b};
      OP_LH:   rload = {{16{sel_h[15]}}, sel_h};
      OP_LHU:  rload = {16'h0, sel_h};
      OP_LW:   rload = word_q;
      default: rload = '0;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign err        = resp_valid && err_q;
  assign rdata      = (resp_valid && !err_q) ? rload : '0;
  assign mem_re     = (state == READ);
  assign mem_we     = (state == WRITE);
  assign mem_addr   = {a_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = mem_we ? wmerge : '0;

endmodule

// File: tb/tb_dmem_rmw_unit.sv
// Randomized bench for dmem_rmw_unit: little- and big-endian
// instances run in lockstep against a transaction-level model.
module tb_dmem_rmw_unit;

  localparam int TO = 15;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  err;
  logic [1:0]  mem_re;
  logic [1:0]  mem_we;
  logic [31:0] rdata [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];

  int n_chk = 0;
  int n_pass = 0;

  logic [5:0] ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  always #5 clk = ~clk;

  dmem_rmw_unit #(
    .ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(TO)
  ) u_le (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready[0]),
    .op(op), .a(a), .wd(wd),
    .resp_valid(resp_valid[0]), .rdata(rdata[0]), .err(err[0]),
    .mem_addr(mem_addr[0]), .mem_re(mem_re[0]),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0])
  );

  dmem_rmw_unit #(
    .ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(TO)
  ) u_be (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready[1]),
    .op(op), .a(a), .wd(wd),
    .resp_valid(resp_valid[1]), .rdata(rdata[1]), .err(err[1]),
    .mem_addr(mem_addr[1]), .mem_re(mem_re[1]),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Whole-transaction reference: n = READ cycle carrying rvalid, 0 = never
  function automatic void model(
    input logic [5:0] o, input logic [31:0] ad, d, w,
    input int n, input bit be,
    output int lat, output logic e, output logic [31:0] rd,
    output int nwe, output logic [31:0] wdat, output int nre);
    int ln, hp;
    logic [7:0] b;
    logic [15:0] h;
    bit bad;
    ln = be ? 3 - int'(ad[1:0]) : int'(ad[1:0]);
    hp = be ? 1 - int'(ad[1]) : int'(ad[1]);
    b = 8'((w >> (8 * ln)) & 32'hFF);
    h = 16'((w >> (16 * hp)) & 32'hFFFF);
    case (o)
      LB, LBU, SB: bad = 1'b0;
      LH, LHU, SH: bad = ad[0];
      LW, SW:      bad = (ad[1:0] != 2'b00);
      default:     bad = 1'b1;
    endcase
    lat = 0; e = 1'b0; rd = '0; nwe = 0; wdat = '0; nre = 0;
    if (bad) begin
      e = 1'b1; lat = 1;
    end else if (o == SW) begin
      lat = 2; nwe = 1; wdat = d;
    end else if (n == 0) begin
      e = 1'b1; lat = TO + 1; nre = TO;
    end else begin
      nre = n;
      lat = n + 1;
      case (o)
        LB:  rd = {{24{b[7]}}, b};
        LBU: rd = {24'h0, b};
        LH:  rd = {{16{h[15]}}, h};
        LHU: rd = {16'h0, h};
        LW:  rd = w;
        SB: begin
          lat = n + 2; nwe = 1;
          wdat = (w & ~(32'hFF << (8 * ln))) | ((d & 32'hFF) << (8 * ln));
        end
        SH: begin
          lat = n + 2; nwe = 1;
          wdat = (w & ~(32'hFFFF << (16 * hp))) |
                 ((d & 32'hFFFF) << (16 * hp));
        end
        default: rd = '0;
      endcase
    end
  endfunction

  task automatic txn(input string nm, input logic [5:0] o,
                     input logic [31:0] ad, d, w, input int n);
    int elat [2];
    logic ee [2];
    logic [31:0] erd [2];
    int enwe [2];
    logic [31:0] ewd [2];
    int enre [2];
    int olat [2];
    logic oerr [2];
    logic [31:0] ord [2];
    int onwe [2];
    logic [31:0] owd [2];
    int onre [2];
    bit seen [2];
    bit both, badaddr, leak;
    int c, rc;
    for (int i = 0; i < 2; i++) begin
      model(o, ad, d, w, n, bit'(i), elat[i], ee[i], erd[i],
            enwe[i], ewd[i], enre[i]);
      olat[i] = 0; oerr[i] = 1'b0; ord[i] = '0;
      onwe[i] = 0; owd[i] = '0; onre[i] = 0; seen[i] = 1'b0;
    end
    both = 1'b0; badaddr = 1'b0; leak = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s/%0d ready", nm, i), req_ready[i], 1);
    op = o; a = ad; wd = d; req_valid = 1'b1;
    mem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op = 6'($urandom); a = $urandom; wd = $urandom;
    c = 0; rc = 0;
    while (!(seen[0] && seen[1]) && c < 60) begin
      c++;
      if (mem_re[0]) begin
        rc++;
        mem_rvalid = (rc == n);
        mem_rdata = (rc == n) ? w : $urandom;
      end else begin
        mem_rvalid = 1'($urandom);
        mem_rdata = $urandom;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mem_re[i] && mem_we[i]) both = 1'b1;
        if ((mem_re[i] || mem_we[i]) &&
            mem_addr[i] !== {ad[31:2], 2'b00}) badaddr = 1'b1;
        if (mem_re[i]) onre[i]++;
        if (mem_we[i]) begin
          onwe[i]++; owd[i] = mem_wdata[i];
        end
        if (resp_valid[i] && !seen[i]) begin
          seen[i] = 1'b1; olat[i] = c;
          ord[i] = rdata[i]; oerr[i] = err[i];
        end else if (err[i]) leak = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s/%0d lat", nm, i), olat[i], elat[i]);
      chk($sformatf("%s/%0d err", nm, i), oerr[i], ee[i]);
      chk($sformatf("%s/%0d rdata", nm, i), ord[i], erd[i]);
      chk($sformatf("%s/%0d nwe", nm, i), onwe[i], enwe[i]);
      chk($sformatf("%s/%0d wdata", nm, i), owd[i], ewd[i]);
      chk($sformatf("%s/%0d nre", nm, i), onre[i], enre[i]);
    end
    chk($sformatf("%s re_we", nm), both, 0);
    chk($sformatf("%s addr", nm), badaddr, 0);
    chk($sformatf("%s errleak", nm), leak, 0);
  endtask

  task automatic abort_test();
    bit rv;
    @(negedge clk);
    op = SH; a = 32'h0000_0020; wd = 32'h0000_CAFE; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("abort/%0d re_before", i), mem_re[i], 1);
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort/%0d re_async", i), mem_re[i], 0);
      chk($sformatf("abort/%0d we_async", i), mem_we[i], 0);
    end
    rv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid != 2'b00 || mem_we != 2'b00) rv = 1'b1;
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    chk("abort quiet", rv, 0);
  endtask

  initial begin
    int n;
    logic [5:0] o;
    #12;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst/%0d flags", i),
          {req_ready[i], resp_valid[i], err[i], mem_re[i], mem_we[i]},
          32'b10000);
      chk($sformatf("rst/%0d rdata", i), rdata[i], 0);
      chk($sformatf("rst/%0d addr", i), mem_addr[i], 0);
      chk($sformatf("rst/%0d wdata", i), mem_wdata[i], 0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    txn("sb_rmw", SB, 32'h1002, 32'h0000_00AB, 32'h1122_3344, 1);
    txn("lb_sx", LB, 32'h2003, 32'h0, 32'h80FF_0000, 2);
    txn("lbu_zx", LBU, 32'h2003, 32'h0, 32'h80FF_0000, 3);
    txn("sh_half", SH, 32'h10, 32'h0000_BEEF, 32'h1234_5678, 1);
    txn("lw_mis", LW, 32'h4001, 32'h0, 32'h0, 1);
    txn("op_bad", 6'b000000, 32'h4000, 32'h0, 32'h0, 1);
    txn("lhu_to", LHU, 32'h0, 32'h0, 32'h0, 0);
    txn("sw", SW, 32'h8, 32'hDEAD_BEEF, 32'h0, 1);
    txn("lh_mis", LH, 32'h3, 32'h0, 32'h0, 1);

    abort_test();
    txn("post_rst", SH, 32'h0000_0022, 32'h0000_1357, 32'hA5A5_5A5A, 2);

    for (int k = 0; k < 60; k++) begin
      o = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) o = 6'($urandom);
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      txn($sformatf("rnd%0d", k), o, $urandom, $urandom, $urandom, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
